// File: rtl/dmem_ctrl_if.sv
// Access bus between a load/store unit and the data-memory controller.
// Ports: req/we/funct3/addr/wdata go master->slave; rdata/busy/done/fault go slave->master.
// Latency and backpressure are owned by the controller: a master issues only while busy is low.
interface dmem_ctrl_if;
  logic        req;     // start an access (honoured only while the controller is idle)
  logic        we;      // 1 = store, 0 = load
  logic [2:0]  funct3;  // access width / signedness
  logic [31:0] addr;    // byte address
  logic [31:0] wdata;   // store data, narrow stores use the low lanes
  logic [31:0] rdata;   // extended load result, held between loads
  logic        busy;    // controller is not idle
  logic        done;    // one-cycle completion pulse
  logic        fault;   // valid with done: illegal or misaligned access

  modport master (
    output req, we, funct3, addr, wdata,
    input  rdata, busy, done, fault
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output rdata, busy, done, fault
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Purpose: single-port data memory with byte/half/word loads and read-modify-write stores.
// Latency: done is high in the cycle sampled by edge N+2 for a load, N+3 for a store and
//          N+1 for a faulting access, where N is the edge that sampled req.
// Backpressure: one access in flight; busy stays high from acceptance through the done
//          cycle and req is ignored until the controller is back in IDLE.
// Ports: clk, reset (synchronous, active-high), bus (dmem_ctrl_if.slave).
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  dmem_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Request fields captured when the access is accepted; the live bus is
  // free to change while busy is high.
  logic          cap_we;
  logic [2:0]    cap_f3;
  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_wdata;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_word;
  logic [31:0]   fetched;

  logic          req_fault;
  logic [31:0]   load_val;
  logic [31:0]   shifted;
  logic [31:0]   wide_wdata;
  logic [3:0]    lane_en;
  logic [31:0]   merged;

  // Address bits above the word index only alias the same words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:AW+2];

  assign word_idx = cap_addr[AW+1:2];
  assign mem_word = mem[word_idx];

  // Legality and alignment are judged on the live request so a fault can be
  // reported without touching the memory.
  always_comb begin
    req_fault = 1'b0;
    case (bus.funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = bus.addr[0];
      3'b010:  req_fault = |bus.addr[1:0];
      3'b100:  req_fault = bus.we;
      3'b101:  req_fault = bus.we | bus.addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  // Load extraction: shift the addressed byte/half down to lane 0, then
  // sign- or zero-extend according to funct3[2].
  always_comb begin
    shifted  = 32'h0;
    load_val = mem_word;
    case (cap_f3[1:0])
      2'b00: begin
        shifted  = mem_word >> {cap_addr[1:0], 3'b000};
        load_val = {{24{~cap_f3[2] & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        shifted  = mem_word >> {cap_addr[1], 4'b0000};
        load_val = {{16{~cap_f3[2] & shifted[15]}}, shifted[15:0]};
      end
      default: load_val = mem_word;
    endcase
  end

  // Store merge: replicate the store data across lanes and pick only the
  // addressed lanes, keeping the rest of the fetched word.
  always_comb begin
    lane_en    = 4'b1111;
    wide_wdata = cap_wdata;
    case (cap_f3[1:0])
      2'b00: begin
        lane_en    = 4'b0001 << cap_addr[1:0];
        wide_wdata = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        lane_en    = cap_addr[1] ? 4'b1100 : 4'b0011;
        wide_wdata = {2{cap_wdata[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        wide_wdata = cap_wdata;
      end
    endcase
    merged = fetched;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged[8*i +: 8] = wide_wdata[8*i +: 8];
    end
  end

  // Memory array: never reset. A reset landing in WRITE suppresses the
  // write so an aborted store leaves memory untouched.
  always_ff @(posedge clk) begin
    if (state == READ) fetched <= mem_word;
    if (state == WRITE && !reset) mem[word_idx] <= merged;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus.rdata <= 32'h0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done  <= 1'b0;
          bus.fault <= 1'b0;
          if (bus.req) begin
            cap_we    <= bus.we;
            cap_f3    <= bus.funct3;
            cap_addr  <= bus.addr[AW+1:0];
            cap_wdata <= bus.wdata;
            bus.busy  <= 1'b1;
            if (req_fault) begin
              // Faulting load clears rdata; faulting store leaves it.
              state     <= DONE;
              bus.done  <= 1'b1;
              bus.fault <= 1'b1;
              if (!bus.we) bus.rdata <= 32'h0;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (cap_we) begin
            state <= WRITE;
          end else begin
            state     <= DONE;
            bus.done  <= 1'b1;
            bus.rdata <= load_val;
          end
        end
        WRITE: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        default: begin
          // DONE: the pulse lasts this one cycle; req here is not sampled.
          state     <= IDLE;
          bus.done  <= 1'b0;
          bus.fault <= 1'b0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, internal data memory depth in 32-bit words (power of two).
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  input  1  sole clock; all state updates on rising edge.
  reset  input  1  synchronous, active-high reset.
  req  input  1  start access; sampled only in IDLE.
  we  input  1  1 = store, 0 = load; sampled with req.
  funct3  input  3  access type: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
  addr  input  32  byte address, driven from ALU result.
  wdata  input  32  store data (rs2); low byte/half used for narrow stores.
  rdata  output  32  load result, extended per funct3.
  busy  output  1  high whenever state is not IDLE.
  done  output  1  one-cycle completion pulse.
  fault  output  1  valid with done; misaligned or illegal access.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-005 IDLE with req=1 and a legal, aligned access SHALL go to READ; with a fault it SHALL go to DONE.
REQ-006 The access SHALL be legal if funct3 is in {000,001,010,100,101} for loads and {000,001,010} for stores; any other code is a fault.
REQ-007 Alignment SHALL be: half requires addr[0]=0; word requires addr[1:0]=00; a violation is a fault.
REQ-008 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo memory size.
REQ-009 READ SHALL fetch the indexed word; a load then goes to DONE, a store goes to WRITE.
REQ-010 WRITE SHALL write back the fetched word with only the addressed byte lanes replaced by wdata (SB: 1 lane at addr[1:0]; SH: 2 lanes at addr[1]; SW: all), then go to DONE.
REQ-011 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-012 Latency from req-sampling edge N SHALL be: load done at N+2, store done at N+3, fault done at N+1.
REQ-013 Load extraction SHALL select the byte/half by addr[1:0]; 000/001 sign-extend, 100/101 zero-extend, 010 pass the word.
REQ-014 rdata SHALL update at load completion and hold until the next load completion or fault.
REQ-015 On a load fault rdata SHALL be 0; on a store fault rdata SHALL be unchanged.
REQ-016 fault SHALL be asserted only in DONE and be 0 otherwise; a faulting store SHALL leave memory unmodified.
REQ-017 req, we, funct3, addr and wdata SHALL be captured in IDLE; changes while busy=1 SHALL be ignored.
REQ-018 req in the DONE cycle SHALL be ignored; a new access starts only from IDLE, so back-to-back loads issue every 3 cycles.

Reset
REQ-019 Reset SHALL force state IDLE, rdata=0, done=0, busy=0 and fault=0 on the next edge.
REQ-020 Memory contents SHALL NOT be reset.
REQ-021 Reset asserted in READ or WRITE SHALL abort the access with no memory write and no done pulse.
REQ-022 Reset has priority over req in the same cycle.

Verification
REQ-023 Directed scenarios the bench SHALL cover:
  SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> rdata=0xDEADBEEF, fault=0; done at N+3 and N+2 respectively.
  After the prior store, LB addr=0x13 -> rdata=0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x12 -> 0xFFFFDEAD; LHU addr=0x10 -> 0x0000BEEF.
  SB addr=0x11 wdata=0x00000055, then LW 0x10 -> 0xDEAD55EF; SH addr=0x12 wdata=0x1234, then LW 0x10 -> 0x123455EF.
  LW addr=0x12 -> done at N+1, fault=1, rdata=0; SH addr=0x11 -> fault=1 and a following LW 0x10 is unchanged; load funct3=011 -> fault=1.
  With DEPTH_WORDS=256, SW addr=0x400 wdata=0xA5A5A5A5, then LW addr=0x0 -> 0xA5A5A5A5 (wrap).
  SW to 0x20 (old 0x0) with reset pulsed during WRITE -> no done pulse, outputs 0, LW 0x20 -> 0x00000000; req toggled while busy -> no extra access.
